// File: rtl/mar_mem_pkg.sv
// Shared widths, types and the preloaded program image for the MAR/RAM unit.
package mar_mem_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam word_t INIT_IMAGE [16] = '{
    8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h0E
  };

  // Image word for any address; words beyond the image are zero.
  function automatic word_t init_word(input int unsigned idx);
    logic [3:0] i4;
    i4 = idx[3:0];
    return (idx < 16) ? INIT_IMAGE[i4] : '0;
  endfunction
endpackage

// File: rtl/mar_reg.sv
// Load/hold register with asynchronous active-low clear.
module mar_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/mar_ram_unit.sv
// Memory address register feeding a 16x8 program RAM; image reloads on reset.
module mar_ram_unit
  import mar_mem_pkg::*;
#(
  parameter int ADDR_W = mar_mem_pkg::ADDR_W,
  parameter int DATA_W = mar_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_load,
  input  logic [ADDR_W-1:0] mar_in,
  output logic [ADDR_W-1:0] mar_out,
  input  logic              mem_load,
  input  logic              mem_oe,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  mar_reg #(.W(ADDR_W)) u_mar (
    .clk   (clk),
    .rst_n (rst),
    .load  (mar_load),
    .d     (mar_in),
    .q     (mar_out)
  );

  // One flop bank per word so the whole image can be restored asynchronously.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [DATA_W-1:0] INIT = DATA_W'(init_word(i));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        mem[i] <= INIT;
      else if (mem_load && (mar_out == ADDR_W'(i)))
        mem[i] <= mem_data_in;
    end
  end

  assign mem_data_out = mem_oe ? mem[mar_out] : '0;
endmodule

// File: tb/tb_mar_ram_unit.sv
// Directed + random checks of mar_ram_unit against an array-based reference.
module tb_mar_ram_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       mar_load, mem_load, mem_oe;
  logic [3:0] mar_in, mar_out;
  logic [7:0] mem_data_in, mem_data_out;

  int passed = 0;
  int total  = 0;

  logic [7:0] ref_mem [16];
  logic [3:0] ref_mar;

  mar_ram_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mar_load     (mar_load),
    .mar_in       (mar_in),
    .mar_out      (mar_out),
    .mem_load     (mem_load),
    .mem_oe       (mem_oe),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] image(input int a);
    case (a)
      0: return 8'h1E;  1: return 8'h2F;  2: return 8'hE0;  3: return 8'hF0;
      14: return 8'h1C; 15: return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  task automatic ref_reset();
    for (int a = 0; a < 16; a++) ref_mem[a] = image(a);
    ref_mar = 4'h0;
  endtask

  function automatic logic [7:0] ref_out();
    return mem_oe ? ref_mem[ref_mar] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge, updating the model from the pre-edge inputs.
  task automatic step();
    if (!rst) ref_reset();
    else begin
      if (mem_load) ref_mem[ref_mar] = mem_data_in;
      if (mar_load) ref_mar = mar_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_addr(input logic [3:0] a);
    mar_in = a; mar_load = 1'b1;
    step();
    mar_load = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    mem_oe = 1'b0;
    load_addr(a);
    mem_oe = 1'b1;
    #1;
    chk(tag, mem_data_out, exp);
  endtask

  initial begin
    rst = 1'b0; mar_load = 1'b0; mem_load = 1'b0; mem_oe = 1'b0;
    mar_in = 4'h0; mem_data_in = 8'h00;
    ref_reset();
    #12;
    chk("reset_mar", {4'h0, mar_out}, 8'h00);
    chk("reset_oe0", mem_data_out, 8'h00);
    mem_oe = 1'b1; #1;
    chk("reset_oe1", mem_data_out, 8'h1E);
    mem_oe = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Write AA to 5, then reset mid-cycle with a write pending.
    load_addr(4'h5);
    mem_data_in = 8'hAA; mem_load = 1'b1;
    step();
    mem_load = 1'b1; mem_data_in = 8'h77;
    mar_in = 4'h9; mar_load = 1'b1;
    #2 rst = 1'b0; #1;
    chk("midreset_mar", {4'h0, mar_out}, 8'h00);
    step();
    mem_load = 1'b0; mar_load = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    read_chk("post_reset_a5", 4'h5, 8'h00);
    read_chk("post_reset_a0", 4'h0, 8'h1E);

    read_chk("seq_a0", 4'h0, 8'h1E);
    read_chk("seq_a1", 4'h1, 8'h2F);
    read_chk("seq_a2", 4'h2, 8'hE0);
    read_chk("seq_a3", 4'h3, 8'hF0);

    load_addr(4'h7);
    mem_data_in = 8'h5C; mem_load = 1'b1;
    step();
    mem_load = 1'b0;
    read_chk("wr_a7", 4'h7, 8'h5C);
    read_chk("wr_a6", 4'h6, 8'h00);

    mem_oe = 1'b0;
    load_addr(4'hE);
    chk("gate_oe0", mem_data_out, 8'h00);
    mem_oe = 1'b1; #1;
    chk("gate_oe1", mem_data_out, 8'h1C);

    // Write-through visibility: old value before the edge, new value after.
    mem_data_in = 8'hC3; mem_load = 1'b1; #1;
    chk("wr_pre_edge", mem_data_out, 8'h1C);
    step();
    mem_load = 1'b0;
    chk("wr_post_edge", mem_data_out, 8'hC3);

    load_addr(4'h4);
    mar_in = 4'h9; mar_load = 1'b1;
    mem_data_in = 8'h33; mem_load = 1'b1;
    step();
    mar_load = 1'b0; mem_load = 1'b0;
    chk("simul_mar", {4'h0, mar_out}, 8'h09);
    read_chk("simul_a4", 4'h4, 8'h33);
    read_chk("simul_a9", 4'h9, 8'h00);

    for (int c = 0; c < 5; c++) begin
      mar_in = 4'(c * 3 + 1);
      step();
      chk("hold_mar", {4'h0, mar_out}, 8'h09);
    end

    // Random traffic, with an occasional reset pulse.
    for (int c = 0; c < 300; c++) begin
      mar_load    = 1'($urandom_range(0, 1));
      mem_load    = ($urandom_range(0, 3) == 0);
      mem_oe      = 1'($urandom_range(0, 1));
      mar_in      = 4'($urandom);
      mem_data_in = 8'($urandom);
      rst         = ($urandom_range(0, 40) != 0);
      #1;
      if (rst) chk("rnd_out_pre", mem_data_out, ref_out());
      step();
      rst = 1'b1;
      #1;
      chk("rnd_mar", {4'h0, mar_out}, {4'h0, ref_mar});
      chk("rnd_out", mem_data_out, ref_out());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
